ps2_rx_stream: RTL
==================

PS2_RX_STREAM -- requirements
Module: ps2_rx_stream

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20, meaning the number of consecutive stable clk_i samples required before kclk/kdata are accepted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte buffer depth; legal values are powers of 2 with FIFO_DEPTH >= 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the clk_i cycles allowed between bit strobes inside a frame.
REQ-004 SHALL have port clk_i, input, 1, system clock.
REQ-005 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port kclk_i, input, 1, raw PS/2 clock (asynchronous).
REQ-007 SHALL have port kdata_i, input, 1, raw PS/2 data (asynchronous).
REQ-008 SHALL have port data_o, output, 8, FIFO head byte.
REQ-009 SHALL have port valid_o, output, 1, FIFO non-empty.
REQ-010 SHALL have port ready_i, input, 1, consumer accepts data_o.
REQ-011 SHALL have port level_o, output, $clog2(FIFO_DEPTH+1), FIFO occupancy.
REQ-012 SHALL have port frame_err_o, output, 1, one-cycle pulse on a bad stop bit or parity.
REQ-013 SHALL have port timeout_err_o, output, 1, one-cycle pulse on a frame abort.
REQ-014 SHALL have port overflow_o, output, 1, one-cycle pulse on a byte dropped because the FIFO is full.

Function
REQ-015 SHALL use only the clk_i domain; no logic is clocked by kclk_i.
REQ-016 SHALL pass each raw input through a 2-flop synchronizer and then a filter that updates its output only after DEBOUNCE_CYCLES equal samples.
REQ-017 SHALL assert an internal bit strobe for exactly one clk_i cycle, in the cycle after the filtered kclk is registered as falling from 1 to 0.
REQ-018 SHALL use FSM states IDLE, DATA, PARITY and STOP, changing state only on a strobe, a timeout or reset.
REQ-019 SHALL, in IDLE, go to DATA on a strobe with kdata=0 (start bit); a strobe with kdata=1 leaves the FSM in IDLE and raises no error.
REQ-020 SHALL, in DATA, shift in 8 bits LSB-first, then go to PARITY.
REQ-021 SHALL, in PARITY, capture the parity bit, then go to STOP.
REQ-022 SHALL, in STOP, push the byte if kdata=1 and parity is valid, otherwise pulse frame_err_o; both cases return to IDLE.
REQ-023 SHALL, when not in IDLE and TIMEOUT_CYCLES pass without a strobe, return to IDLE, discard the partial byte and pulse timeout_err_o.
REQ-024 SHALL make a pushed byte visible on data_o/valid_o in the clk_i cycle after the STOP strobe.
REQ-025 SHALL pop the FIFO on valid_o && ready_i; data_o is the head byte and holds stable while valid_o=1 && ready_i=0.
REQ-026 SHALL, on a push with the FIFO full, drop the byte, pulse overflow_o and leave the FIFO contents unchanged, unless a pop occurs in the same cycle, in which case the push succeeds.
REQ-027 SHALL, on a simultaneous push and pop with the FIFO empty, accept the push and ignore the pop (valid_o was 0).
REQ-028 SHALL keep level_o equal to pushes minus pops, saturating at 0 and FIFO_DEPTH, with the pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, while rst_i=1, force: FSM=IDLE, FIFO empty, level_o=0, valid_o=0, data_o=0, all error pulses=0, and filter outputs=1 (idle bus).
REQ-030 SHALL, on reset mid-frame, discard the partial byte with no error pulse, and restart frame detection only after the next start bit.

Configuration
REQ-031 SHALL, with PS2_PARITY_CHECK_EN defined, require odd parity over the 8 data bits plus the parity bit, and treat a mismatch as a frame error per REQ-022.
REQ-032 SHALL, without PS2_PARITY_CHECK_EN, capture and ignore the parity bit, so that only the stop bit can cause frame_err_o.

Structure
REQ-033 SHALL place in shared package ps2_pkg: the FSM state enum, the constant PS2_DATA_BITS=8, and the constant PS2_FRAME_BITS=11.
REQ-034 SHALL implement the synchronizer plus filter as sub-module ps2_filter, instantiated once per input line.

Verification
REQ-035 SHALL cover: frame 0x1C with parity 0 and stop 1 -> data_o=0x1C, valid_o=1, level_o=1, no error pulses.
REQ-036 SHALL cover: frame 0xF0 with parity 0 (invalid) -> frame_err_o pulses once and no push occurs (with macro defined); without the macro, 0xF0 is pushed.
REQ-037 SHALL cover: 9 frames 0x01..0x09 sent with ready_i=0 and FIFO_DEPTH=8 -> level_o=8, overflow_o pulses once, and draining yields 0x01..0x08.
REQ-038 SHALL cover: start bit plus 3 data bits followed by TIMEOUT_CYCLES+1 idle cycles -> timeout_err_o pulses once and a following 0x5A frame is received correctly.
REQ-039 SHALL cover: 2-cycle glitches on kclk_i mid-frame with DEBOUNCE_CYCLES=20 -> no extra strobes and the byte is received intact.
REQ-040 SHALL cover: rst_i asserted after data bit 4, then a 0x29 frame -> only 0x29 appears, with level_o=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
//   ps2_state_e       : frame FSM states
//   PS2_DATA_BITS     : data bits per frame
//   PS2_FRAME_BITS    : start + data + parity + stop
//   ps2_odd_parity_ok : odd-parity check over data plus parity bit
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                             input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizer plus glitch filter for one raw PS/2 line.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset; output forced to 1 (idle bus)
//   raw_i  : asynchronous raw line
//   filt_o : filtered line; changes only after DEBOUNCE_CYCLES equal samples
module ps2_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // cnt_q counts consecutive synchronized samples that differ from the
  // current output; any agreeing sample restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_rx_stream.sv
// PS/2 device-to-host receiver with a byte FIFO and valid/ready output.
//   clk_i, rst_i     : system clock, asynchronous active-high reset
//   kclk_i, kdata_i  : raw asynchronous PS/2 clock and data
//   data_o, valid_o  : FIFO head byte and non-empty flag
//   ready_i          : consumer accepts data_o (pop on valid_o && ready_i)
//   level_o          : FIFO occupancy
//   frame_err_o      : pulse on bad stop bit (or bad parity when checked)
//   timeout_err_o    : pulse when a frame is aborted for lack of clock edges
//   overflow_o       : pulse when a good byte is dropped on a full FIFO
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_rx_stream
  import ps2_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             kclk_i,
  input  logic                             kdata_i,
  output logic [7:0]                       data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
  output logic                             frame_err_o,
  output logic                             timeout_err_o,
  output logic                             overflow_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(PS2_DATA_BITS);

  // ---------------------------------------------------------------------------
  // Input conditioning and falling-edge strobe
  // ---------------------------------------------------------------------------
  logic kclk_f;
  logic kdata_f;

  ps2_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter_kclk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw_i (kclk_i),
    .filt_o(kclk_f)
  );

  ps2_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter_kdata (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw_i (kdata_i),
    .filt_o(kdata_f)
  );

  logic kclk_prev_q;
  logic strobe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kclk_prev_q <= 1'b1;
      strobe_q    <= 1'b0;
    end else begin
      kclk_prev_q <= kclk_f;
      strobe_q    <= kclk_prev_q & ~kclk_f;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  ps2_state_e               state_q;
  logic [BW-1:0]            bit_cnt_q;
  logic [PS2_DATA_BITS-1:0] shift_q;
  logic [TW-1:0]            timer_q;
  logic                     frame_err_q;
  logic                     timeout_err_q;
  logic                     parity_ok;
  logic                     frame_ok;
  logic                     push;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;
  assign parity_ok = ps2_odd_parity_ok(shift_q, parity_q);
`else
  // Parity bit is clocked through the PARITY state but never stored.
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = kdata_f & parity_ok;
  // Combinational push so the byte lands in the FIFO on the STOP strobe edge.
  assign push     = strobe_q & (state_q == StStop) & frame_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      timer_q       <= '0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      if (strobe_q) begin
        timer_q <= '0;
        unique case (state_q)
          StIdle: begin
            // A high "start bit" is line noise; stay idle silently.
            if (!kdata_f) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end
          end
          StData: begin
            shift_q   <= {kdata_f, shift_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
              state_q <= StParity;
            end
          end
          StParity: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= kdata_f;
`endif
            state_q  <= StStop;
          end
          StStop: begin
            frame_err_q <= ~frame_ok;
            state_q     <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q       <= StIdle;
          timer_q       <= '0;
          timeout_err_q <= 1'b1;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign frame_err_o   = frame_err_q;
  assign timeout_err_o = timeout_err_q;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          full;
  logic          valid;
  logic          pop;
  logic          push_ok;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign valid   = (level_q != '0);
  assign pop     = valid & ready_i;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push & full & ~pop;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_ok && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (!push_ok && pop) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  assign valid_o    = valid;
  assign data_o     = valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule
